// File: rtl/adc_serial_modulator.sv
// adc_serial_modulator
//   Receives the ADC's MSB-first serial stream and its NEW_BYTE marker,
//   re-times both into the clk domain, samples every bit at mid-period and
//   rebuilds the byte. It also drives a 1-bit modulated carrier (ASK, FSK,
//   BPSK or raw NRZ) from the bit currently being received.
//
// Ports
//   clk        in   system clock (50 MHz)
//   rst        in   asynchronous reset, active low
//   serial_in  in   serial data, MSB first, asynchronous to clk
//   new_byte   in   byte marker, high during the MSB bit period, asynchronous
//   mode       in   00 ASK, 01 FSK, 10 BPSK, 11 raw NRZ (latched at byte start)
//   byte_out   out  last fully received byte
//   byte_valid out  one-clk pulse when byte_out updates
//   cur_bit    out  bit currently being modulated
//   mod_out    out  registered modulated output
//   sync_err   out  one-clk pulse when a byte marker arrives mid-byte
module adc_serial_modulator #(
  parameter int BIT_CYCLES = 25000,
  parameter int HALF1      = 25,
  parameter int HALF0      = 50,
  parameter int CW         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       new_byte,
  input  logic [1:0] mode,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       cur_bit,
  output logic       mod_out,
  output logic       sync_err
);

  typedef enum logic [1:0] {IDLE, ALIGN, RECV} state_t;

  localparam logic [1:0] MODE_ASK  = 2'b00;
  localparam logic [1:0] MODE_FSK  = 2'b01;
  localparam logic [1:0] MODE_BPSK = 2'b10;

  localparam logic [CW-1:0] ALIGN_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] H1_LAST    = CW'(HALF1 - 1);
  localparam logic [CW-1:0] H0_LAST    = CW'(HALF0 - 1);

  logic          r_ser_s1, r_ser_s2;
  logic          r_nb_s1, r_nb_s2, r_nb_s3;
  state_t        r_state, w_next;
  logic [CW-1:0] r_timer;
  logic [2:0]    r_bit_cnt;
  logic [6:0]    r_shreg;
  logic [1:0]    r_mode;
  logic [7:0]    r_byte_out;
  logic          r_byte_valid, r_sync_err, r_cur_bit, r_mod_out;
  logic [CW-1:0] r_car_cnt;
  logic          r_carrier, r_h0_sel;

  logic          w_nb_rise, w_sample, w_complete, w_restart, w_sync_err;
  logic          w_use_h0;
  logic [CW-1:0] w_h_last;

  // Two-flop synchronizers; the third new_byte flop is only for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ser_s1 <= 1'b0;
      r_ser_s2 <= 1'b0;
      r_nb_s1  <= 1'b0;
      r_nb_s2  <= 1'b0;
      r_nb_s3  <= 1'b0;
    end else begin
      r_ser_s1 <= serial_in;
      r_ser_s2 <= r_ser_s1;
      r_nb_s1  <= new_byte;
      r_nb_s2  <= r_nb_s1;
      r_nb_s3  <= r_nb_s2;
    end
  end

  assign w_nb_rise = r_nb_s2 & ~r_nb_s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // A marker that coincides with the 8th sample lets the byte finish and then
  // starts the next one; any other mid-byte marker throws the partial byte away.
  always_comb begin
    w_next     = r_state;
    w_sample   = 1'b0;
    w_complete = 1'b0;
    w_restart  = 1'b0;
    w_sync_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_nb_rise) begin
          w_next    = ALIGN;
          w_restart = 1'b1;
        end
      end
      ALIGN:   w_sample = (r_timer == ALIGN_LAST);
      RECV:    w_sample = (r_timer == BIT_LAST);
      default: w_next   = IDLE;
    endcase
    if (r_state != IDLE) begin
      w_complete = w_sample && (r_bit_cnt == 3'd7);
      if (w_nb_rise && !w_complete) begin
        w_sample   = 1'b0;
        w_sync_err = 1'b1;
        w_restart  = 1'b1;
        w_next     = ALIGN;
      end else if (w_complete) begin
        w_restart = w_nb_rise;
        w_next    = w_nb_rise ? ALIGN : IDLE;
      end else if (w_sample) begin
        w_next = RECV;
      end
    end
  end

  // Bit timing, shift register and byte assembly. bit_cnt wraps to 0 on the
  // 8th sample, so no explicit clear is needed at the end of a byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer      <= '0;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_mode       <= 2'b00;
      r_cur_bit    <= 1'b0;
      r_byte_out   <= '0;
      r_byte_valid <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_byte_valid <= w_complete;
      r_sync_err   <= w_sync_err;
      if (w_restart) begin
        r_timer   <= '0;
        r_bit_cnt <= '0;
        r_mode    <= mode;
      end else if (r_state != IDLE) begin
        if (w_sample) begin
          r_timer   <= '0;
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end else begin
          r_timer <= r_timer + CW'(1);
        end
      end
      if (w_sample) begin
        r_shreg   <= {r_shreg[5:0], r_ser_s2};
        r_cur_bit <= r_ser_s2;
      end
      if (w_complete) r_byte_out <= {r_shreg, r_ser_s2};
    end
  end

  assign w_use_h0 = (r_mode == MODE_FSK) && !r_cur_bit;
  assign w_h_last = w_use_h0 ? H0_LAST : H1_LAST;

  // Free-running carrier. A change of half-period restarts the counter but
  // leaves the level alone, keeping FSK phase-continuous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_car_cnt <= '0;
      r_carrier <= 1'b0;
      r_h0_sel  <= 1'b0;
    end else begin
      r_h0_sel <= w_use_h0;
      if (w_use_h0 != r_h0_sel) begin
        r_car_cnt <= '0;
      end else if (r_car_cnt == w_h_last) begin
        r_car_cnt <= '0;
        r_carrier <= ~r_carrier;
      end else begin
        r_car_cnt <= r_car_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mod_out <= 1'b0;
    end else begin
      case (r_mode)
        MODE_ASK:  r_mod_out <= r_carrier & r_cur_bit;
        MODE_FSK:  r_mod_out <= r_carrier;
        MODE_BPSK: r_mod_out <= r_carrier ^ ~r_cur_bit;
        default:   r_mod_out <= r_cur_bit;
      endcase
    end
  end

  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign cur_bit    = r_cur_bit;
  assign mod_out    = r_mod_out;
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_adc_serial_modulator.sv
// Testbench for adc_serial_modulator with a short bit period (16 clk) and
// fast carriers (half-periods 2 and 4 clk). Bytes are driven as whole serial
// frames; every output cycle is logged and each frame is then judged against
// what the byte, the mode and the nominal timing say should appear.
module tb_adc_serial_modulator;

  localparam int BITC = 16;
  localparam int LOGN = 16384;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic       new_byte;
  logic [1:0] mode;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       cur_bit;
  logic       mod_out;
  logic       sync_err;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;

  logic       modLog [0:LOGN-1];
  logic       cbLog  [0:LOGN-1];
  logic [7:0] boLog  [0:LOGN-1];
  int         vCyc[$];
  int         vVal[$];
  int         sCyc[$];

  adc_serial_modulator #(
    .BIT_CYCLES(16),
    .HALF1     (2),
    .HALF0     (4),
    .CW        (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .new_byte  (new_byte),
    .mode      (mode),
    .byte_out  (byte_out),
    .byte_valid(byte_valid),
    .cur_bit   (cur_bit),
    .mod_out   (mod_out),
    .sync_err  (sync_err)
  );

  // 100 MHz-style clock; only the cycle count matters here.
  always #5 clk = ~clk;

  // Cycle number = count of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every output on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      modLog[cyc] = mod_out;
      cbLog[cyc]  = cur_bit;
      boLog[cyc]  = byte_out;
    end
    if (byte_valid) begin
      vCyc.push_back(cyc);
      vVal.push_back(int'(byte_out));
    end
    if (sync_err) sCyc.push_back(cyc);
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    testsRun++;
    if (obs != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Pulls a measured value onto the nearest end of the allowed range, so an
  // in-range measurement compares equal and an out-of-range one is reported.
  function automatic int clampTo(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Drives the first nbits bits of b, BITC clocks each, marker on the MSB only.
  // The mode pin is scrambled after the first bit to show it is latched.
  task automatic applyStimulus(input logic [7:0] b, input int nbits,
                               input logic [1:0] m, output int c0);
    @(posedge clk); #1;
    c0   = cyc;
    mode = m;
    for (int k = 0; k < nbits; k++) begin
      new_byte  = (k == 0);
      serial_in = b[7-k];
      if (k == 1) mode = ~m;
      repeat (BITC) @(posedge clk);
      #1;
    end
    new_byte = 1'b0;
  endtask

  // Sample of bit k lands at edge c0+11+16k (3 sync + 8 align); mod_out
  // follows one clk later. Each bit is judged over a 10-clk window inside
  // its stable region.
  task automatic analyzeByte(input int c0, input logic [7:0] b,
                             input logic [1:0] m, input int expSync);
    int cnt = 0, val = -1, off = -1, sc = 0;
    int changes = 0, odd = 0, ones, trans, w, len;
    logic bitv;
    int runs[$];
    foreach (vCyc[i])
      if (vCyc[i] >= c0 && vCyc[i] < c0 + 140) begin
        cnt++;
        val = vVal[i];
        off = vCyc[i] - c0;
      end
    foreach (sCyc[i])
      if (sCyc[i] >= c0 && sCyc[i] < c0 + 140) sc++;
    checkOutput("valid_count", cnt, 1);
    checkOutput("byte_out", val, int'(b));
    checkOutput("valid_latency", off, 3 + 7 * BITC + BITC / 2);
    checkOutput("sync_err_count", sc, expSync);

    for (int k = 0; k < 8; k++) begin
      bitv = b[7-k];
      if (k > 0 && bitv != b[8-k]) changes++;
      w = c0 + 11 + BITC * k + 4;
      ones = 0;
      trans = 0;
      for (int c = w; c < w + 10; c++) begin
        if (modLog[c]) ones++;
        if (c > w && modLog[c] != modLog[c-1]) trans++;
      end
      checkOutput($sformatf("cur_bit[%0d]", 7 - k), int'(cbLog[w + 5]), int'(bitv));
      case (m)
        2'b11: checkOutput($sformatf("nrz_level[%0d]", 7 - k), ones, bitv ? 10 : 0);
        2'b00:
          if (bitv) checkOutput($sformatf("ask_toggles[%0d]", 7 - k), trans, clampTo(trans, 4, 5));
          else      checkOutput($sformatf("ask_zero[%0d]", 7 - k), ones, 0);
        2'b01:
          if (bitv) checkOutput($sformatf("fsk_mark[%0d]", 7 - k), trans, clampTo(trans, 4, 5));
          else      checkOutput($sformatf("fsk_space[%0d]", 7 - k), trans, clampTo(trans, 2, 3));
        default: checkOutput($sformatf("bpsk_toggles[%0d]", 7 - k), trans, clampTo(trans, 4, 5));
      endcase
    end

    // Run lengths across the whole byte; first and last runs are partial.
    len = 1;
    for (int c = c0 + 14; c <= c0 + 138; c++) begin
      if (modLog[c] == modLog[c-1]) len++;
      else begin
        runs.push_back(len);
        len = 1;
      end
    end
    if (runs.size() > 0) void'(runs.pop_front());
    if (m == 2'b01) begin
      foreach (runs[i]) if (runs[i] < 2) odd++;
      checkOutput("fsk_glitch_runs", odd, 0);
    end else if (m == 2'b10) begin
      foreach (runs[i]) if (runs[i] != 2) odd++;
      checkOutput("bpsk_phase_flips", odd, clampTo(odd, changes, 2 * changes));
    end
  endtask

  task automatic runByte(input logic [7:0] b, input logic [1:0] m, input int expSync);
    int c0;
    applyStimulus(b, 8, m, c0);
    repeat (14) @(posedge clk);
    #1;
    analyzeByte(c0, b, m, expSync);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_byte_out"},   int'(byte_out),   0);
    checkOutput({tag, "_byte_valid"}, int'(byte_valid), 0);
    checkOutput({tag, "_cur_bit"},    int'(cur_bit),    0);
    checkOutput({tag, "_mod_out"},    int'(mod_out),    0);
    checkOutput({tag, "_sync_err"},   int'(sync_err),   0);
  endtask

  initial begin
    int cA, c0, cnt, sc;
    logic [7:0] rb;
    logic [1:0] rm;
    rst       = 1'b0;
    serial_in = 1'b0;
    new_byte  = 1'b0;
    mode      = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b1;
    repeat (6) @(posedge clk);

    $display("[TB] directed bytes in all four modes");
    runByte(8'hA5, 2'b11, 0);
    runByte(8'hA5, 2'b00, 0);
    runByte(8'h0F, 2'b01, 0);
    runByte(8'hF0, 2'b10, 0);

    $display("[TB] resync after three bits");
    applyStimulus(8'h96, 3, 2'b11, cA);
    applyStimulus(8'h3C, 8, 2'b11, c0);
    repeat (14) @(posedge clk);
    #1;
    cnt = 0;
    foreach (vCyc[i]) if (vCyc[i] >= cA && vCyc[i] < c0) cnt++;
    checkOutput("aborted_valid", cnt, 0);
    checkOutput("byte_out_kept", int'(boLog[c0 + 20]), 8'hF0);
    analyzeByte(c0, 8'h3C, 2'b11, 1);

    $display("[TB] reset mid-byte");
    applyStimulus(8'hE7, 3, 2'b00, cA);
    rst = 1'b0;
    #1;
    checkAllZero("midreset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    runByte(8'h81, 2'b11, 0);

    $display("[TB] random bytes");
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(255));
      rm = 2'($urandom_range(3));
      runByte(rb, rm, 0);
    end

    sc = 0;
    foreach (sCyc[i]) sc++;
    checkOutput("total_sync_err", sc, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
